mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port on-chip memory between two requesters: the external SPI packetizer ("ext") and the processor core ("core").
- Issues at most one access per cycle and tags each read so its return data is routed back to the requester that issued it.
- One instance sits in front of each of the activation, parameter and instruction memories, replacing direct sel_ext muxing.

Parameters:
- WIDTH_ADDR, 11, memory address width
- WIDTH_DATA, 8, memory data width
- READ_LATENCY, 2, cycles from mem_rden to valid mem_rdata (1..4)
- MAX_EXT_STREAK, 4, maximum consecutive ext grants while core is waiting (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ext_req  in  1  ext access request
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  WIDTH_ADDR  ext address
- ext_wdata  in  WIDTH_DATA  ext write data
- ext_lock  in  1  ext burst in progress; ext holds the port
- ext_gnt  out  1  ext access accepted this cycle
- ext_rvalid  out  1  ext read data valid
- ext_rdata  out  WIDTH_DATA  ext read data
- core_req, core_we, core_addr, core_wdata  in  1/1/WIDTH_ADDR/WIDTH_DATA  core request, same meaning as ext
- core_gnt  out  1  core access accepted this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  WIDTH_DATA  core read data
- mem_addr  out  WIDTH_ADDR  memory address
- mem_wdata  out  WIDTH_DATA  memory write data
- mem_wren  out  1  memory write strobe
- mem_rden  out  1  memory read strobe
- mem_rdata  in  WIDTH_DATA  memory read data
- busy  out  1  any read in flight or any grant this cycle

Behaviour:
- Arbitration is combinational on the current req and state.
  - A transfer occurs in the cycle where req && gnt.
  - Memory outputs are registered, so mem_* asserts one cycle after the grant.
  - At most one of ext_gnt and core_gnt is high in any cycle.
- Priority, highest first:
  1. ext_lock && ext_req: grant ext.
  2. Core pending and streak == MAX_EXT_STREAK: grant core.
  3. ext_req: grant ext.
  4. core_req: grant core.
- streak (4-bit counter):
  - +1 on each ext grant while core_req is high.
  - Clears on any core grant, or when core_req is low.
  - Saturates at MAX_EXT_STREAK.
  - ext_lock bypasses the streak limit; starvation of core during a lock is accepted.
- Issue register: on grant, latch addr and wdata; set mem_wren = we or mem_rden = !we for exactly one cycle. With no grant, mem_wren = mem_rden = 0 and addr/wdata hold their last values.
- Read return tracking:
  - Shift register of depth READ_LATENCY carries a valid bit and an owner bit (0 = ext, 1 = core), loaded when mem_rden is driven.
  - At the tail, the owner's rvalid pulses for 1 cycle and its rdata is captured from mem_rdata.
  - Total latency from read grant to rvalid = 1 + READ_LATENCY cycles.
  - Back-to-back reads from either requester are fully pipelined.
  - rdata holds its value until the next rvalid for that requester.
- Writes produce no rvalid.
- Reset, also when asserted mid-operation:
  - All outputs 0; streak = 0; return pipeline flushed. In-flight reads are dropped and no rvalid is produced for them.
  - gnt stays 0 in the reset cycle regardless of req.
- No FSM beyond the streak counter and the issue/return pipelines.
- Requesters hold req/we/addr/wdata stable until gnt.

Decomposition:
- Shared package:
  - Owner encoding localparams OWNER_EXT = 1'b0 and OWNER_CORE = 1'b1.
  - Default widths matching the packetizer memories: act 11/8, param 13/128, inst 6/80.
- Sub-module: rd_tag_pipe, a parameterised valid+owner shift register of depth READ_LATENCY with synchronous flush.

Test Plan:
- Single ext read to addr 0x05, mem returns 0xA5 → mem_rden at T+1, ext_rvalid = 1 with ext_rdata = 0xA5 at T+3 (READ_LATENCY = 2), core_rvalid stays 0.
- ext and core request continuously, no lock, MAX_EXT_STREAK = 4 → grant pattern is ext×4, core×1, repeating; never both gnt high.
- ext_lock high with both requesting for 10 cycles → ext_gnt for all 10; core_gnt 0; core granted on the cycle after lock drops.
- Interleaved reads ext@0x10, core@0x20, ext@0x30 on consecutive cycles, mem returns 0x11/0x22/0x33 → rvalids ext, core, ext on consecutive cycles with matching data.
- Core write addr 0x7FF, data 0x3C → mem_wren for one cycle with mem_addr 0x7FF and mem_wdata 0x3C; no rvalid.
- reset asserted one cycle after an ext read grant → no ext_rvalid is ever produced; all outputs are 0 the cycle after reset.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: read-owner tags, default
// widths of the packetizer memories and the streak counter helper.
package mem_port_arbiter_pkg;

    localparam logic OWNER_EXT  = 1'b0;
    localparam logic OWNER_CORE = 1'b1;

    localparam int ACT_WIDTH_ADDR   = 11;
    localparam int ACT_WIDTH_DATA   = 8;
    localparam int PARAM_WIDTH_ADDR = 13;
    localparam int PARAM_WIDTH_DATA = 128;
    localparam int INST_WIDTH_ADDR  = 6;
    localparam int INST_WIDTH_DATA  = 80;

    localparam int STREAK_W = 4;

    function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] val,
                                                    input logic [STREAK_W-1:0] max);
        return (val >= max) ? max : val + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Valid+owner shift register tracking reads in flight through the memory;
// the tail lines up with the cycle the memory presents read data.
module rd_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic flush_i,
    input  logic vld_i,
    input  logic owner_i,
    output logic vld_o,
    output logic owner_o,
    output logic busy_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] owner_q;

    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            vld_q   <= '0;
            owner_q <= '0;
        end else begin
            vld_q[0]   <= vld_i;
            owner_q[0] <= owner_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]   <= vld_q[i-1];
                owner_q[i] <= owner_q[i-1];
            end
        end
    end

    assign vld_o   = vld_q[DEPTH-1];
    assign owner_o = owner_q[DEPTH-1];
    assign busy_o  = |vld_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port memory: ext has priority
// except when core has waited MAX_EXT_STREAK ext grants; reads are tagged by owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH_ADDR     = ACT_WIDTH_ADDR,
    parameter int WIDTH_DATA     = ACT_WIDTH_DATA,
    parameter int READ_LATENCY   = 2,
    parameter int MAX_EXT_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [WIDTH_ADDR-1:0] ext_addr,
    input  logic [WIDTH_DATA-1:0] ext_wdata,
    input  logic                  ext_lock,
    output logic                  ext_gnt,
    output logic                  ext_rvalid,
    output logic [WIDTH_DATA-1:0] ext_rdata,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [WIDTH_ADDR-1:0] core_addr,
    input  logic [WIDTH_DATA-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [WIDTH_DATA-1:0] core_rdata,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic [WIDTH_DATA-1:0] mem_wdata,
    output logic                  mem_wren,
    output logic                  mem_rden,
    input  logic [WIDTH_DATA-1:0] mem_rdata,
    output logic                  busy
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_EXT_STREAK);

    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [WIDTH_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH_DATA-1:0] wdata_q, wdata_d;
    logic                  wren_q, wren_d;
    logic                  rden_q, rden_d;
    logic                  owner_q, owner_d;
    logic [WIDTH_DATA-1:0] ext_rdata_q, core_rdata_q;
    logic                  tail_vld, tail_owner, pipe_busy;

    always_comb begin
        ext_gnt  = 1'b0;
        core_gnt = 1'b0;
        if (!reset) begin
            // A lock overrides the anti-starvation rule on purpose.
            if (ext_lock && ext_req)                    ext_gnt  = 1'b1;
            else if (core_req && streak_q == STREAK_MAX) core_gnt = 1'b1;
            else if (ext_req)                           ext_gnt  = 1'b1;
            else if (core_req)                          core_gnt = 1'b1;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (core_gnt || !core_req) streak_d = '0;
        else if (ext_gnt)          streak_d = sat_inc(streak_q, STREAK_MAX);

        addr_d  = addr_q;
        wdata_d = wdata_q;
        owner_d = owner_q;
        wren_d  = 1'b0;
        rden_d  = 1'b0;
        if (ext_gnt) begin
            addr_d  = ext_addr;
            wdata_d = ext_wdata;
            owner_d = OWNER_EXT;
            wren_d  = ext_we;
            rden_d  = !ext_we;
        end else if (core_gnt) begin
            addr_d  = core_addr;
            wdata_d = core_wdata;
            owner_d = OWNER_CORE;
            wren_d  = core_we;
            rden_d  = !core_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wren_q       <= 1'b0;
            rden_q       <= 1'b0;
            owner_q      <= OWNER_EXT;
            ext_rdata_q  <= '0;
            core_rdata_q <= '0;
        end else begin
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            owner_q  <= owner_d;
            if (ext_rvalid)  ext_rdata_q  <= mem_rdata;
            if (core_rvalid) core_rdata_q <= mem_rdata;
        end
    end

    rd_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_rd_tag_pipe (
        .clk_i   (clk),
        .flush_i (reset),
        .vld_i   (rden_q),
        .owner_i (owner_q),
        .vld_o   (tail_vld),
        .owner_o (tail_owner),
        .busy_o  (pipe_busy)
    );

    // Return data is forwarded in the cycle the memory presents it, then held.
    assign ext_rvalid  = !reset && tail_vld && (tail_owner == OWNER_EXT);
    assign core_rvalid = !reset && tail_vld && (tail_owner == OWNER_CORE);
    assign ext_rdata   = ext_rvalid  ? mem_rdata : ext_rdata_q;
    assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wren  = wren_q;
    assign mem_rden  = rden_q;
    assign busy      = !reset && (ext_gnt || core_gnt || rden_q || pipe_busy);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against
// a transaction-level model of arbitration and tagged read returns.
module tb_mem_port_arbiter;

    localparam int WA   = 11;
    localparam int WD   = 8;
    localparam int RL   = 2;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
    logic [WA-1:0] ext_addr = '0;
    logic [WD-1:0] ext_wdata = '0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [WA-1:0] core_addr = '0;
    logic [WD-1:0] core_wdata = '0;
    logic          ext_gnt, ext_rvalid, core_gnt, core_rvalid;
    logic [WD-1:0] ext_rdata, core_rdata;
    logic [WA-1:0] mem_addr;
    logic [WD-1:0] mem_wdata;
    logic          mem_wren, mem_rden, busy;
    logic [WD-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .WIDTH_ADDR(WA), .WIDTH_DATA(WD), .READ_LATENCY(RL), .MAX_EXT_STREAK(MAXS)
    ) dut (
        .clk(clk), .reset(reset),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Behavioural SRAM: data for a read strobed in cycle k is driven in cycle k+RL.
    logic [WD-1:0] sram     [0:(1<<WA)-1];
    logic [WD-1:0] spec_mem [0:(1<<WA)-1];
    typedef struct { int due; logic [WD-1:0] data; } mrd_t;
    typedef struct { int due; logic owner; logic [WD-1:0] data; } exp_t;
    mrd_t mq[$];
    mrd_t mtmp;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wren) sram[mem_addr] <= mem_wdata;
        if (mem_rden) mq.push_back('{cyc + RL, sram[mem_addr]});
    end

    always @(posedge clk) begin
        #1;
        while (mq.size() > 0 && mq[0].due < cyc) mtmp = mq.pop_front();
        if (mq.size() > 0 && mq[0].due == cyc) begin
            mtmp = mq.pop_front();
            mem_rdata <= mtmp.data;
        end else begin
            mem_rdata <= WD'($urandom);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ext_req = 1'b0; ext_lock = 1'b0; ext_we = 1'b0;
        core_req = 1'b0; core_we = 1'b0;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [WA+2*WD+WD+WD+7-1:0] outs;
        reset = 1'b1;
        ext_req = 1'b1; core_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({ext_gnt, core_gnt} !== 2'b00) begin
            errors++; $display("FAIL reset_gnt got %b want 00", {ext_gnt, core_gnt});
        end
        step();
        reset = 1'b0;
        idle();
        @(negedge clk);
        outs = {mem_addr, mem_wdata, ext_rdata, core_rdata, mem_wren, mem_rden,
                ext_rvalid, core_rvalid, busy, ext_gnt, core_gnt};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", outs);
        end
    endtask

    task automatic test_single_read();
        sram[5] = 8'hA5; spec_mem[5] = 8'hA5;
        do_reset();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 11'h005;
        @(negedge clk);
        checks++;
        if (ext_gnt !== 1'b1) begin errors++; $display("FAIL sr_gnt got %b want 1", ext_gnt); end
        step(); ext_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_rden, mem_addr} !== {1'b1, 11'h005}) begin
            errors++; $display("FAIL sr_mem_rden got %b/%h want 1/005", mem_rden, mem_addr);
        end
        step(); @(negedge clk);
        checks++;
        if ({ext_rvalid, core_rvalid} !== 2'b00) begin
            errors++; $display("FAIL sr_early_rvalid got %b want 00", {ext_rvalid, core_rvalid});
        end
        step(); @(negedge clk);
        checks++;
        if ({ext_rvalid, core_rvalid, ext_rdata} !== {2'b10, 8'hA5}) begin
            errors++; $display("FAIL sr_return got %b%b/%h want 10/a5", ext_rvalid, core_rvalid, ext_rdata);
        end
        step(); @(negedge clk);
        checks++;
        if ({ext_rvalid, ext_rdata} !== {1'b0, 8'hA5}) begin
            errors++; $display("FAIL sr_hold got %b/%h want 0/a5", ext_rvalid, ext_rdata);
        end
    endtask

    task automatic test_fairness();
        logic xe;
        do_reset();
        ext_req = 1'b1; ext_addr = 11'h100; core_req = 1'b1; core_addr = 11'h200;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            xe = (i % (MAXS + 1)) < MAXS;
            checks++;
            if ({ext_gnt, core_gnt} !== {xe, !xe}) begin
                errors++; $display("FAIL fair_cycle%0d got %b want %b", i, {ext_gnt, core_gnt}, {xe, !xe});
            end
            step();
        end
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        ext_req = 1'b1; ext_lock = 1'b1; core_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({ext_gnt, core_gnt} !== 2'b10) begin
                errors++; $display("FAIL lock_cycle%0d got %b want 10", i, {ext_gnt, core_gnt});
            end
            step();
        end
        ext_lock = 1'b0;
        @(negedge clk);
        checks++;
        if ({ext_gnt, core_gnt} !== 2'b01) begin
            errors++; $display("FAIL lock_release got %b want 01", {ext_gnt, core_gnt});
        end
        step();
        idle();
    endtask

    task automatic test_interleave();
        logic [1:0] xg, xv;
        logic [WD-1:0] xd;
        sram[11'h010] = 8'h11; sram[11'h020] = 8'h22; sram[11'h030] = 8'h33;
        spec_mem[11'h010] = 8'h11; spec_mem[11'h020] = 8'h22; spec_mem[11'h030] = 8'h33;
        do_reset();
        for (int j = 0; j < 7; j++) begin
            idle();
            if (j == 0) begin ext_req = 1'b1; ext_addr = 11'h010; end
            if (j == 1) begin core_req = 1'b1; core_addr = 11'h020; end
            if (j == 2) begin ext_req = 1'b1; ext_addr = 11'h030; end
            @(negedge clk);
            xg = (j == 0 || j == 2) ? 2'b10 : (j == 1) ? 2'b01 : 2'b00;
            xv = (j == 3 || j == 5) ? 2'b10 : (j == 4) ? 2'b01 : 2'b00;
            xd = (j == 3) ? 8'h11 : (j == 4) ? 8'h22 : 8'h33;
            checks++;
            if ({ext_gnt, core_gnt} !== xg) begin
                errors++; $display("FAIL il_gnt%0d got %b want %b", j, {ext_gnt, core_gnt}, xg);
            end
            checks++;
            if ({ext_rvalid, core_rvalid} !== xv ||
                (xv[1] && ext_rdata !== xd) || (xv[0] && core_rdata !== xd)) begin
                errors++; $display("FAIL il_ret%0d got %b e=%h c=%h want %b d=%h",
                                   j, {ext_rvalid, core_rvalid}, ext_rdata, core_rdata, xv, xd);
            end
            step();
        end
        idle();
    endtask

    task automatic test_write();
        do_reset();
        core_req = 1'b1; core_we = 1'b1; core_addr = 11'h7FF; core_wdata = 8'h3C;
        spec_mem[11'h7FF] = 8'h3C;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 0) begin
                checks++;
                if (core_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b want 1", core_gnt); end
            end
            if (j == 1) begin
                checks++;
                if ({mem_wren, mem_rden, mem_addr, mem_wdata} !== {2'b10, 11'h7FF, 8'h3C}) begin
                    errors++; $display("FAIL wr_issue got %b%b/%h/%h want 10/7ff/3c",
                                       mem_wren, mem_rden, mem_addr, mem_wdata);
                end
            end
            if (j == 2) begin
                checks++;
                if (mem_wren !== 1'b0) begin errors++; $display("FAIL wr_pulse got %b want 0", mem_wren); end
            end
            checks++;
            if ({ext_rvalid, core_rvalid} !== 2'b00) begin
                errors++; $display("FAIL wr_no_rvalid%0d got %b want 00", j, {ext_rvalid, core_rvalid});
            end
            step();
            core_req = 1'b0; core_we = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [WA+2*WD+WD+WD+7-1:0] outs;
        do_reset();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 11'h005;
        @(negedge clk);
        checks++;
        if (ext_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt got %b want 1", ext_gnt); end
        for (int j = 1; j < 7; j++) begin
            step();
            idle();
            reset = (j == 1);
            @(negedge clk);
            if (j == 2) begin
                outs = {mem_addr, mem_wdata, ext_rdata, core_rdata, mem_wren, mem_rden,
                        ext_rvalid, core_rvalid, busy, ext_gnt, core_gnt};
                checks++;
                if (outs !== '0) begin errors++; $display("FAIL rm_outputs got %h want 0", outs); end
            end
            checks++;
            if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid%0d got 1 want 0", j); end
        end
    endtask

    task automatic test_random();
        exp_t eq[$];
        exp_t t;
        logic e_p = 1'b0, e_we = 1'b0, c_p = 1'b0, c_we = 1'b0;
        logic [WA-1:0] e_a = '0, c_a = '0;
        logic [WD-1:0] e_d = '0, c_d = '0, last_e = '0, last_c = '0;
        logic xe, xc, xev, xcv;
        int s = 0;
        int c;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (!e_p && $urandom_range(0, 1) == 1) begin
                e_p = 1'b1; e_we = ($urandom_range(0, 3) == 0); e_a = WA'($urandom); e_d = WD'($urandom);
            end
            if (!c_p && $urandom_range(0, 2) != 0) begin
                c_p = 1'b1; c_we = ($urandom_range(0, 3) == 0); c_a = WA'($urandom); c_d = WD'($urandom);
            end
            ext_req = e_p; ext_we = e_we; ext_addr = e_a; ext_wdata = e_d;
            core_req = c_p; core_we = c_we; core_addr = c_a; core_wdata = c_d;
            ext_lock = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            c = cyc;
            xe = (ext_lock && e_p) || (e_p && !(c_p && s == MAXS));
            xc = c_p && !xe;
            checks++;
            if ({ext_gnt, core_gnt} !== {xe, xc}) begin
                errors++; $display("FAIL rnd_gnt k=%0d got %b want %b", k, {ext_gnt, core_gnt}, {xe, xc});
            end
            if (xc || !c_p) s = 0;
            else if (xe && s < MAXS) s++;
            if (xe) begin
                if (e_we) spec_mem[e_a] = e_d;
                else eq.push_back('{c + 1 + RL, 1'b0, spec_mem[e_a]});
                e_p = 1'b0;
            end
            if (xc) begin
                if (c_we) spec_mem[c_a] = c_d;
                else eq.push_back('{c + 1 + RL, 1'b1, spec_mem[c_a]});
                c_p = 1'b0;
            end
            xev = 1'b0; xcv = 1'b0;
            if (eq.size() > 0 && eq[0].due == c) begin
                t = eq.pop_front();
                if (t.owner) begin xcv = 1'b1; last_c = t.data; end
                else begin xev = 1'b1; last_e = t.data; end
            end
            checks++;
            if ({ext_rvalid, core_rvalid, ext_rdata, core_rdata} !== {xev, xcv, last_e, last_c}) begin
                errors++; $display("FAIL rnd_ret k=%0d got %b%b %h %h want %b%b %h %h", k,
                                   ext_rvalid, core_rvalid, ext_rdata, core_rdata, xev, xcv, last_e, last_c);
            end
            step();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < (1 << WA); i++) begin
            sram[i] = WD'($urandom);
            spec_mem[i] = sram[i];
        end
        test_reset();
        test_single_read();
        test_fairness();
        test_lock();
        test_interleave();
        test_write();
        test_reset_mid();
        test_random();
        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
